// File: rtl/axi_slave_mem.sv
// ---------------------------------------------------------------------------
// axi_slave_mem
//
// AXI4 memory-mapped slave backed by an internal word-addressed register
// array. Read and write channels run independently and concurrently.
// FIXED, INCR and WRAP bursts are supported; errors are reported per beat
// (out-of-range address) or per burst (illegal size/burst/wrap shape, and
// on writes a WLAST that does not match the beat count).
//
// Handshake rule used on every channel: a transfer happens on the rising
// edge where VALID and READY are both 1. VALID never waits for READY, and
// the payload of a VALID output is held until its transfer.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   AR* / R*                  read address and read data channels
//   AW* / W* / B*             write address, write data, write response
//   dbg_r_state               read FSM state (0 R_IDLE, 1 R_DATA)
//   dbg_w_state               write FSM state (0 W_IDLE, 1 W_DATA, 2 W_RESP)
// ---------------------------------------------------------------------------
module axi_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  // read address channel
  output logic                    ARREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  input  logic [LEN_WIDTH-1:0]    ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  // read data channel
  output logic                    RVALID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic                    RLAST,
  output logic [1:0]              RRESP,
  input  logic                    RREADY,
  // write address channel
  output logic                    AWREADY,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  input  logic [LEN_WIDTH-1:0]    AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  // write data channel
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  // write response channel
  output logic                    BVALID,
  output logic [1:0]              BRESP,
  input  logic                    BREADY,
  // FSM observation
  output logic                    dbg_r_state,
  output logic [1:0]              dbg_w_state
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = $clog2(MEM_DEPTH);
  localparam int TOP_BIT    = BYTE_SHIFT + IDX_WIDTH;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  // -------------------------------------------------------------------------
  // Address helpers
  // -------------------------------------------------------------------------
  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return |a[ADDR_WIDTH-1:TOP_BIT];
  endfunction

  function automatic logic [IDX_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[BYTE_SHIFT +: IDX_WIDTH];
  endfunction

  // A burst is rejected as a whole when its shape cannot be served: beats
  // wider than the bus, the reserved burst code, or a WRAP whose length is
  // not 2/4/8/16 beats or whose start is not aligned to the beat size.
  function automatic logic burst_illegal(input logic [ADDR_WIDTH-1:0] a,
                                         input logic [LEN_WIDTH-1:0]  len,
                                         input logic [2:0]            size,
                                         input logic [1:0]            burst);
    logic [ADDR_WIDTH-1:0] align_mask;
    logic                  ill;
    align_mask = (ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1);
    ill = 1'b0;
    if (size > 3'(BYTE_SHIFT)) ill = 1'b1;
    if (burst == 2'b11) ill = 1'b1;
    if (burst == BURST_WRAP) begin
      if (!((len == LEN_WIDTH'(1)) || (len == LEN_WIDTH'(3)) ||
            (len == LEN_WIDTH'(7)) || (len == LEN_WIDTH'(15))))
        ill = 1'b1;
      if ((a & align_mask) != '0) ill = 1'b1;
    end
    return ill;
  endfunction

  // Address of the beat following address a. WRAP keeps the bits above the
  // wrap block and lets only the in-block offset roll over.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [LEN_WIDTH-1:0]  len,
                                                      input logic [2:0]            size,
                                                      input logic [1:0]            burst);
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] block;
    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] nxt;
    step  = ADDR_WIDTH'(1) << size;
    block = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    mask  = block - ADDR_WIDTH'(1);
    case (burst)
      BURST_FIXED: nxt = a;
      BURST_WRAP:  nxt = (a & ~mask) | ((a + step) & mask);
      default:     nxt = a + step;
    endcase
    return nxt;
  endfunction

  // -------------------------------------------------------------------------
  // Storage (not reset)
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // -------------------------------------------------------------------------
  // Read channel
  // -------------------------------------------------------------------------
  r_state_t              r_state, r_state_nx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_illegal;
  logic [LEN_WIDTH-1:0]  r_cnt;        // index of the beat on RDATA

  logic                  ar_hs, r_hs;
  logic                  ar_illegal, ar_bad;
  logic [ADDR_WIDTH-1:0] rn_addr;
  logic                  rn_bad;

  assign ar_hs      = ARREADY & ARVALID;
  assign r_hs       = RVALID & RREADY;
  assign ar_illegal = burst_illegal(ARADDR, ARLEN, ARSIZE, ARBURST);
  assign ar_bad     = ar_illegal | out_of_range(ARADDR);
  assign rn_addr    = next_addr(r_addr, r_len, r_size, r_burst);
  assign rn_bad     = r_illegal | out_of_range(rn_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_state_nx;
  end

  always_comb begin
    r_state_nx = r_state;
    ARREADY    = 1'b0;
    RVALID     = 1'b0;
    case (r_state)
      R_IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) r_state_nx = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        if (RREADY && (r_cnt == r_len)) r_state_nx = R_IDLE;
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

  // Each beat's data is registered one handshake ahead, so RDATA/RRESP/RLAST
  // hold naturally while the master stalls. A load on the same edge as a
  // write commit sees the pre-write word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
      RDATA     <= '0;
      RRESP     <= RESP_OKAY;
      RLAST     <= 1'b0;
    end else if (ar_hs) begin
      r_addr    <= ARADDR;
      r_len     <= ARLEN;
      r_size    <= ARSIZE;
      r_burst   <= ARBURST;
      r_illegal <= ar_illegal;
      r_cnt     <= '0;
      RDATA     <= ar_bad ? '0 : mem[word_idx(ARADDR)];
      RRESP     <= ar_bad ? RESP_SLVERR : RESP_OKAY;
      RLAST     <= (ARLEN == '0);
    end else if (r_hs) begin
      if (r_cnt == r_len) begin
        RLAST <= 1'b0;
      end else begin
        r_addr <= rn_addr;
        r_cnt  <= r_cnt + LEN_WIDTH'(1);
        RDATA  <= rn_bad ? '0 : mem[word_idx(rn_addr)];
        RRESP  <= rn_bad ? RESP_SLVERR : RESP_OKAY;
        RLAST  <= ((r_cnt + LEN_WIDTH'(1)) == r_len);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Write channel
  // -------------------------------------------------------------------------
  w_state_t              w_state, w_state_nx;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [LEN_WIDTH-1:0]  w_len;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_illegal;
  logic [LEN_WIDTH-1:0]  w_cnt;        // index of the beat being accepted
  logic                  w_err;        // sticky error for the current burst

  logic                  aw_hs, w_hs;
  logic                  aw_illegal;
  logic                  w_last_beat, w_oor, w_beat_err;
  logic                  mem_we;

  assign aw_hs       = AWREADY & AWVALID;
  assign w_hs        = WREADY & WVALID;
  assign aw_illegal  = burst_illegal(AWADDR, AWLEN, AWSIZE, AWBURST);
  assign w_last_beat = (w_cnt == w_len);
  assign w_oor       = out_of_range(w_addr);
  assign w_beat_err  = w_oor | (WLAST != w_last_beat);
  assign mem_we      = w_hs & ~w_illegal & ~w_oor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = w_state;
    AWREADY    = 1'b0;
    WREADY     = 1'b0;
    BVALID     = 1'b0;
    case (w_state)
      W_IDLE: begin
        AWREADY = 1'b1;
        if (AWVALID) w_state_nx = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        // The beat count, not WLAST, decides where the burst ends.
        if (WVALID && w_last_beat) w_state_nx = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_state_nx = W_IDLE;
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_addr    <= '0;
      w_len     <= '0;
      w_size    <= '0;
      w_burst   <= '0;
      w_illegal <= 1'b0;
      w_cnt     <= '0;
      w_err     <= 1'b0;
      BRESP     <= RESP_OKAY;
    end else if (aw_hs) begin
      w_addr    <= AWADDR;
      w_len     <= AWLEN;
      w_size    <= AWSIZE;
      w_burst   <= AWBURST;
      w_illegal <= aw_illegal;
      w_cnt     <= '0;
      w_err     <= aw_illegal;
    end else if (w_hs) begin
      if (w_last_beat) begin
        BRESP <= (w_err | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
      end else begin
        w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
        w_cnt  <= w_cnt + LEN_WIDTH'(1);
        w_err  <= w_err | w_beat_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (WSTRB[b]) mem[word_idx(w_addr)][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  assign dbg_r_state = r_state;
  assign dbg_w_state = w_state;

endmodule

// File: tb/tb_axi_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_axi_slave_mem
//
// Directed scenarios plus a randomized burst mix. Drivers push the expected
// read beats / write responses into queues computed from a word-array model
// of the memory; negedge monitors pop and compare whenever the DUT completes
// an R or B transfer.
// ---------------------------------------------------------------------------
module tb_axi_slave_mem;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LW    = 8;
  localparam int DEPTH = 256;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          ARREADY, ARVALID, RVALID, RLAST, RREADY;
  logic [AW-1:0] ARADDR;
  logic [LW-1:0] ARLEN;
  logic [2:0]    ARSIZE;
  logic [1:0]    ARBURST, RRESP;
  logic [DW-1:0] RDATA;
  logic          AWREADY, AWVALID, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic [AW-1:0] AWADDR;
  logic [LW-1:0] AWLEN;
  logic [2:0]    AWSIZE;
  logic [1:0]    AWBURST, BRESP;
  logic [DW-1:0] WDATA;
  logic [3:0]    WSTRB;
  logic          dbg_r_state;
  logic [1:0]    dbg_w_state;

  axi_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ARREADY(ARREADY), .ARADDR(ARADDR), .ARVALID(ARVALID), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .RVALID(RVALID), .RDATA(RDATA), .RLAST(RLAST), .RRESP(RRESP), .RREADY(RREADY),
    .AWREADY(AWREADY), .AWADDR(AWADDR), .AWVALID(AWVALID), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
    .dbg_r_state(dbg_r_state), .dbg_w_state(dbg_w_state)
  );

  // ---------------------------------------------------------------- state
  int checks = 0;
  int errors = 0;
  logic [DW+2:0] exp_q[$];      // {RLAST, RRESP, RDATA}
  logic [1:0]    b_exp_q[$];
  logic [31:0]   model_mem [DEPTH];
  logic [31:0]   wdata_tab [256];
  logic [3:0]    wstrb_tab [256];
  bit            rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int i,
                                            input int len, input int size, input int burst);
    longint s, step, blk, lower;
    s    = longint'(start);
    step = longint'(1) << size;
    case (burst)
      1: return 32'(s + i * step);
      2: begin
        blk   = (len + 1) * step;
        lower = (s / blk) * blk;
        return 32'(lower + (s - lower + i * step) % blk);
      end
      default: return start;
    endcase
  endfunction

  function automatic bit illegal(input logic [31:0] start, input int len,
                                 input int size, input int burst);
    if (size > 2 || burst == 3) return 1'b1;
    if (burst == 2)
      return !(len == 1 || len == 3 || len == 7 || len == 15) || ((start % (32'd1 << size)) != 0);
    return 1'b0;
  endfunction

  function automatic bit oor(input logic [31:0] a);
    return (a >> 10) != 0;
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'((a >> 2) & 32'd255);
  endfunction

  // ---------------------------------------------------------------- driver tasks
  task automatic wait_ready(input int which, input string name);
    bit ok;
    int n = 0;
    forever begin
      @(negedge clk);
      case (which)
        0:       ok = ARREADY;
        1:       ok = AWREADY;
        default: ok = WREADY;
      endcase
      @(posedge clk); #1;
      if (ok) break;
      n++;
      if (n > 500) begin
        checks++; errors++;
        $display("FAIL %s_timeout: ready got 0 expected 1", name);
        break;
      end
    end
  endtask

  task automatic wait_idle(input int which, output int n);
    n = 0;
    while (((which == 0) ? ARREADY : AWREADY) !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL idle_timeout: channel %0d got busy expected idle", which);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input int size,
                          input int burst, input int bad_beat, output int cyc);
    bit          ill, err;
    logic [31:0] a;
    time         t0;
    int          n;
    ill = illegal(addr, len, size, burst);
    err = ill;
    AWADDR = addr; AWLEN = LW'(len); AWSIZE = 3'(size); AWBURST = 2'(burst);
    AWVALID = 1'b1;
    wait_ready(1, "aw_hs");
    t0 = $time;
    AWVALID = 1'b0;
    chk("wready_after_aw", WREADY, 1);
    for (int i = 0; i <= len; i++) begin
      WDATA  = wdata_tab[i];
      WSTRB  = wstrb_tab[i];
      WLAST  = (i == len) != (i == bad_beat);
      WVALID = 1'b1;
      wait_ready(2, "w_hs");
      a = beat_addr(addr, i, len, size, burst);
      if (oor(a)) err = 1'b1;
      else if (!ill) begin
        for (int b = 0; b < 4; b++)
          if (wstrb_tab[i][b]) model_mem[idx(a)][8*b +: 8] = wdata_tab[i][8*b +: 8];
      end
      if (WLAST != (i == len)) err = 1'b1;
    end
    cyc = int'(($time - t0) / 10);
    WVALID = 1'b0;
    WLAST  = 1'b0;
    b_exp_q.push_back(err ? 2'b10 : 2'b00);
    chk("bvalid_after_last_w", BVALID, 1);
    wait_idle(1, n);
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input int size,
                         input int burst, output int cyc);
    bit          ill;
    logic [31:0] a;
    ill = illegal(addr, len, size, burst);
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, i, len, size, burst);
      if (ill || oor(a)) exp_q.push_back({(i == len), 2'b10, 32'h0});
      else               exp_q.push_back({(i == len), 2'b00, model_mem[idx(a)]});
    end
    ARADDR = addr; ARLEN = LW'(len); ARSIZE = 3'(size); ARBURST = 2'(burst);
    ARVALID = 1'b1;
    wait_ready(0, "ar_hs");
    ARVALID = 1'b0;
    chk("rvalid_after_ar", RVALID, 1);
    chk("arready_low_in_burst", ARREADY, 0);
    wait_idle(0, cyc);
    chk("r_all_beats_seen", exp_q.size(), 0);
  endtask

  // background ready generation
  initial begin
    RREADY = 1'b1;
    BREADY = 1'b1;
    forever begin
      @(posedge clk); #1;
      RREADY = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      BREADY = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------------------------------------------------------- scoreboard monitors
  logic [DW+2:0] held;
  logic [DW+2:0] r_exp;
  bit            stall_pending = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending && RVALID) chk("r_hold_while_stalled", {RLAST, RRESP, RDATA}, held);
      if (RVALID && RREADY) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_extra_beat: got data %h expected no beat", RDATA);
        end else begin
          r_exp = exp_q.pop_front();
          chk("r_beat", {RLAST, RRESP, RDATA}, r_exp);
        end
      end
      stall_pending = RVALID && !RREADY;
      held = {RLAST, RRESP, RDATA};
    end
  end

  always @(negedge clk) begin
    if (!rst && BVALID && BREADY) begin
      if (b_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_extra_resp: got resp %b expected none", BRESP);
      end else begin
        chk("bresp", BRESP, b_exp_q.pop_front());
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  int c, cw, cr, n;
  int rsel, ssel, addr_r, size_r, burst_r, len_r, bad_r;
  logic [31:0] old_w, new_w;

  initial begin
    rst = 1'b1;
    ARVALID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0;
    AWVALID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0;
    WVALID = 0; WDATA = 0; WSTRB = 0; WLAST = 0;
    repeat (2) @(negedge clk);
    chk("rst_arready", ARREADY, 1);
    chk("rst_awready", AWREADY, 1);
    chk("rst_rvalid",  RVALID, 0);
    chk("rst_rlast",   RLAST, 0);
    chk("rst_rdata",   RDATA, 0);
    chk("rst_rresp",   RRESP, 0);
    chk("rst_wready",  WREADY, 0);
    chk("rst_bvalid",  BVALID, 0);
    chk("rst_bresp",   BRESP, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // fill all of memory with one 256-beat burst, then read it back
    for (int i = 0; i < 256; i++) begin wdata_tab[i] = $urandom; wstrb_tab[i] = 4'hF; end
    do_write(32'h0, 255, 2, 1, -1, c);
    do_read(32'h0, 255, 2, 1, c);

    // INCR write A0..A3 at 0x10, read back
    for (int i = 0; i < 4; i++) begin wdata_tab[i] = 32'hA0 + i; wstrb_tab[i] = 4'hF; end
    do_write(32'h10, 3, 2, 1, -1, c);
    do_read(32'h10, 3, 2, 1, c);

    // WRAP read: 0x18, 0x1C, 0x10, 0x14
    do_read(32'h18, 3, 2, 2, c);

    // random RREADY over an 8-beat read
    rnd_ready = 1'b1;
    do_read(32'h20, 7, 2, 1, c);
    rnd_ready = 1'b0;

    // strobes: 0xFFFFFFFF then 0x12345678 with WSTRB=0101 -> 0xFF34FF78
    wdata_tab[0] = 32'hFFFF_FFFF; wstrb_tab[0] = 4'hF;
    do_write(32'h40, 0, 2, 1, -1, c);
    wdata_tab[0] = 32'h1234_5678; wstrb_tab[0] = 4'b0101;
    do_write(32'h40, 0, 2, 1, -1, c);
    do_read(32'h40, 0, 2, 1, c);

    // out of range: read 0x400, write 0x404 must not alias onto word 1
    do_read(32'h400, 0, 2, 1, c);
    wdata_tab[0] = 32'hDEAD_BEEF; wstrb_tab[0] = 4'hF;
    do_write(32'h404, 0, 2, 1, -1, c);
    do_read(32'h4, 0, 2, 1, c);

    // early WLAST on beat 1 of a 4-beat burst
    for (int i = 0; i < 4; i++) begin wdata_tab[i] = $urandom; wstrb_tab[i] = 4'hF; end
    do_write(32'h50, 3, 2, 1, 1, c);
    chk("early_wlast_beats", c, 4);
    do_read(32'h50, 3, 2, 1, c);

    // illegal bursts
    do_read(32'h60, 3, 2, 3, c);
    do_write(32'h60, 3, 2, 3, -1, c);
    do_read(32'h60, 3, 2, 1, c);
    do_read(32'h70, 1, 3, 1, c);
    do_read(32'h74, 3, 2, 2, c);

    // concurrent disjoint 8-beat write and read
    for (int i = 0; i < 8; i++) begin wdata_tab[i] = $urandom; wstrb_tab[i] = 4'hF; end
    fork
      do_write(32'h300, 7, 2, 1, -1, cw);
      do_read(32'h100, 7, 2, 1, cr);
    join
    chk("conc_write_cycles", cw, 8);
    chk("conc_read_cycles", cr, 8);

    // same-word collision: read beat loads on the write commit edge
    repeat (2) begin @(posedge clk); #1; end
    AWADDR = 32'h80; AWLEN = 0; AWSIZE = 2; AWBURST = 1; AWVALID = 1'b1;
    wait_ready(1, "col_aw");
    AWVALID = 1'b0;
    old_w = model_mem[32];
    new_w = ~old_w;
    exp_q.push_back({1'b1, 2'b00, old_w});
    b_exp_q.push_back(2'b00);
    ARADDR = 32'h80; ARLEN = 0; ARSIZE = 2; ARBURST = 1; ARVALID = 1'b1;
    WDATA = new_w; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
    @(negedge clk);
    chk("col_arready", ARREADY, 1);
    chk("col_wready", WREADY, 1);
    @(posedge clk); #1;
    ARVALID = 1'b0; WVALID = 1'b0; WLAST = 1'b0;
    model_mem[32] = new_w;
    wait_idle(0, n);
    wait_idle(1, n);
    do_read(32'h80, 0, 2, 1, c);

    // reset during beat 2 of a read and of a write
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 8; i++) wdata_tab[i] = $urandom;
    exp_q.push_back({1'b0, 2'b00, model_mem[64]});
    exp_q.push_back({1'b0, 2'b00, model_mem[65]});
    ARADDR = 32'h100; ARLEN = 7; ARSIZE = 2; ARBURST = 1; ARVALID = 1'b1;
    AWADDR = 32'h200; AWLEN = 7; AWSIZE = 2; AWBURST = 1; AWVALID = 1'b1;
    @(posedge clk); #1;
    ARVALID = 1'b0; AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      WDATA = wdata_tab[i]; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
      @(posedge clk); #1;
      model_mem[128 + i] = wdata_tab[i];
    end
    WDATA = wdata_tab[2];
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    WVALID = 1'b0;
    @(negedge clk);
    chk("post_rst_rvalid", RVALID, 0);
    chk("post_rst_wready", WREADY, 0);
    chk("post_rst_bvalid", BVALID, 0);
    chk("post_rst_arready", ARREADY, 1);
    chk("post_rst_awready", AWREADY, 1);
    chk("post_rst_r_beats", exp_q.size(), 0);
    @(posedge clk); #1;
    do_read(32'h200, 7, 2, 1, c);
    for (int i = 0; i < 8; i++) begin wdata_tab[i] = $urandom; wstrb_tab[i] = 4'hF; end
    do_write(32'h100, 7, 2, 1, -1, c);
    do_read(32'h100, 7, 2, 1, c);

    // randomized mix
    rnd_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      rsel = $urandom_range(0, 9);
      addr_r = (rsel < 7) ? $urandom_range(0, 255) * 4 : 32'h3C0 + $urandom_range(0, 31) * 4;
      ssel = $urandom_range(0, 5);
      size_r = (ssel <= 3) ? 2 : ((ssel == 4) ? $urandom_range(0, 1) : 3);
      if (size_r < 2 && $urandom_range(0, 1) == 1) addr_r = addr_r + $urandom_range(0, 3);
      burst_r = $urandom_range(0, 3);
      if (burst_r == 2 && $urandom_range(0, 3) != 0) len_r = (2 << $urandom_range(0, 3)) - 1;
      else len_r = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len_r; i++) begin wdata_tab[i] = $urandom; wstrb_tab[i] = 4'($urandom); end
        bad_r = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len_r) : -1;
        do_write(32'(addr_r), len_r, size_r, burst_r, bad_r, c);
      end else begin
        do_read(32'(addr_r), len_r, size_r, burst_r, c);
      end
    end
    rnd_ready = 1'b0;

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("r_queue_drained", exp_q.size(), 0);
    chk("b_queue_drained", b_exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_slave_mem.md
# axi_slave_mem

AXI4 memory-mapped slave with independent read and write channels backed by an internal word-addressed register array. It generalises the read-only slave: data width, memory depth and length width are parameters, the write address/data/response channels are added, and FIXED, INCR and WRAP bursts are supported with per-beat error responses. It sits on the CPU-side AXI interconnect as the on-chip data/instruction RAM endpoint.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data bus width in bits; 32 or 64
- LEN_WIDTH, 8, width of ARLEN/AWLEN; beats = LEN+1
- MEM_DEPTH, 256, words in memory; power of two
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-high reset
- ARREADY  out  1  read address accept
- ARADDR  in  ADDR_WIDTH  read start byte address
- ARVALID  in  1  read address valid
- ARLEN  in  LEN_WIDTH  read beats minus one
- ARSIZE  in  3  bytes per beat = 2^ARSIZE
- ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
- RVALID  out  1  read data valid
- RDATA  out  DATA_WIDTH  read data
- RLAST  out  1  final read beat
- RRESP  out  2  00 OKAY, 10 SLVERR
- RREADY  in  1  master accepts the read beat
- AWREADY/AWADDR/AWVALID/AWLEN/AWSIZE/AWBURST: as the AR* signals, for writes
- WDATA  in  DATA_WIDTH  write data
- WSTRB  in  DATA_WIDTH/8  byte-lane enables
- WLAST  in  1  master's final-beat marker
- WVALID  in  1  write data valid
- WREADY  out  1  slave accepts the write beat
- BVALID  out  1  write response valid
- BRESP  out  2  00 OKAY, 10 SLVERR
- BREADY  in  1  master accepts the write response

## Operation
- Word index = addr[log2(DATA_WIDTH/8) +: log2(MEM_DEPTH)]. A beat is out of range when the upper address bits are nonzero; it reads 0 or skips the write, and returns SLVERR.
- Burst address step: FIXED keeps the address; INCR adds 2^SIZE.
- WRAP wraps within a block of (LEN+1)*2^SIZE bytes. It requires LEN ∈ {1,3,7,15} and an aligned start address; otherwise the whole burst returns SLVERR.
- The following make the whole burst SLVERR: SIZE > log2(DATA_WIDTH/8), and BURST = 11. Reads return RDATA=0; writes perform no memory update.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On the AR handshake, latch the burst fields, load RDATA/RRESP for beat 0 into registers, and go to R_DATA.
  - R_DATA: RVALID=1. On each R handshake, load the next beat into the registers. After the handshake of beat LEN, go to R_IDLE.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: AWREADY=1. On the AW handshake, latch the burst fields and go to W_DATA.
  - W_DATA: WREADY=1. On each W handshake, write the strobed bytes of the current address and advance the address. After beat LEN, go to W_RESP.
  - W_RESP: BVALID=1 until BREADY, then go to W_IDLE.
- BRESP is SLVERR if any of the following occurred during the burst: an out-of-range beat, an illegal burst, or a WLAST mismatch (WLAST=1 before beat LEN, or WLAST=0 on beat LEN).
- The burst always ends after LEN+1 beats, regardless of WLAST.
- Read and write FSMs run concurrently.
- Same-word collision, where a read beat loads on the edge a write commits: the read returns the old data.
- Memory contents are not reset.

## Timing
- Reset values:
  - ARREADY=1, AWREADY=1
  - RVALID=0, RLAST=0, RDATA=0, RRESP=00
  - WREADY=0, BVALID=0, BRESP=00
- Reset asserted mid-burst aborts both FSMs to idle and discards the burst; memory keeps any beats already written.
- AR handshake at cycle N gives RVALID=1 with beat 0 at N+1. With RREADY held high, one beat is returned per cycle.
- RDATA, RRESP and RLAST stay stable while RVALID=1 and RREADY=0.
- RLAST=1 only on beat LEN.
- ARREADY is low from N+1 until the cycle after the last R handshake, giving one idle cycle between bursts.
- AW handshake at cycle N gives WREADY=1 at N+1. The memory updates on each W handshake edge, so a following read sees the data.
- The last W handshake at cycle M gives BVALID=1 at M+1. AWREADY returns the cycle after the B handshake.
- Beat counters are LEN_WIDTH bits wide. ARLEN=255 produces 256 beats with no counter overflow.

## Test plan
- Write INCR: AW addr 0x10, LEN=3, SIZE=2, data 0xA0..0xA3, WSTRB=F -> BRESP=00 one cycle after beat 3. A subsequent INCR read of 0x10 LEN=3 returns 0xA0..0xA3 with RLAST on the 4th beat.
- WRAP read: addr 0x18, LEN=3, SIZE=2 (DATA_WIDTH=32) -> words are read in the order 0x18, 0x1C, 0x10, 0x14; all RRESP=00.
- Backpressure and strobes:
  - Toggle RREADY randomly during an 8-beat read -> RDATA is held while stalled; exactly 8 beats are delivered.
  - Write 0xFFFFFFFF then 0x12345678 with WSTRB=0101 -> the word reads 0xFF34FF78.
- Errors:
  - Read addr 0x400 with MEM_DEPTH=256 -> RDATA=0, RRESP=10.
  - Write with WLAST=1 on beat 1 of LEN=3 -> 4 beats are accepted, BRESP=10.
  - ARBURST=11 -> every beat returns SLVERR.
- Concurrency: an 8-beat write and an 8-beat read to disjoint regions run together -> both complete with OKAY and no stall cycles attributable to the other channel. A same-word collision returns the old data.
- Reset mid-burst: assert rst during beat 2 of a read and beat 2 of a write -> the next cycle shows RVALID=0, WREADY=0, BVALID=0, ARREADY=1, AWREADY=1. A new burst then completes normally.
